// File: rtl/trap_filter_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : trap_filter_sequencer_if
// Purpose  : Event hand-off bundle between the trapezoidal-filter event
//            sequencer and its downstream consumer (valid/ready).
// Signals  : ev_valid      event available (driven by master)
//            ev_ready      consumer accepts (driven by slave)
//            ev_amplitude  signed peak amplitude of the event
//            ev_timestamp  timestamp of the trigger sample
//            ev_pileup     second crossing seen inside the peak window
// Revision : 1.0 - initial release
// ============================================================================
interface trap_filter_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int TS_W   = 32
);
  logic                     ev_valid;
  logic                     ev_ready;
  logic signed [DATA_W-1:0] ev_amplitude;
  logic [TS_W-1:0]          ev_timestamp;
  logic                     ev_pileup;

  modport master (
    output ev_valid, ev_amplitude, ev_timestamp, ev_pileup,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_amplitude, ev_timestamp, ev_pileup,
    output ev_ready
  );
endinterface
`default_nettype wire

// File: rtl/trap_filter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : trap_filter_sequencer
// Purpose  : Holds the trapezoidal filter in reset after power-up/restart,
//            waits for the filter pipeline to settle, then arms a threshold
//            trigger on the filter output, captures peak amplitude and
//            timestamp over a fixed window and hands the event downstream.
//            A dead-time / re-arm policy counts crossings that are missed.
// Ports    : clk           system clock (rising edge)
//            reset         asynchronous reset, active low
//            enable        level, arms triggering
//            restart       single-cycle soft re-initialisation
//            threshold     signed trigger level
//            filter_data   signed filter output
//            filter_rst_n  active-low reset to the filter
//            ev            event valid/ready bundle (master side)
//            drop_count    saturating count of missed crossings
//            busy          high while in PEAK, REPORT or DEAD
// Revision : 1.0 - initial release
// ============================================================================
module trap_filter_sequencer #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int TS_WIDTH         = 32,
  parameter int FLUSH_CYCLES     = 4,
  parameter int SETTLE_CYCLES    = 64,
  parameter int PEAK_WINDOW      = 16,
  parameter int DEAD_CYCLES      = 32
) (
  input  wire logic                               clk,
  input  wire logic                               reset,
  input  wire logic                               enable,
  input  wire logic                               restart,
  input  wire logic signed [SIZE_FILTER_DATA-1:0] threshold,
  input  wire logic signed [SIZE_FILTER_DATA-1:0] filter_data,
  output logic                                    filter_rst_n,
  trap_filter_sequencer_if.master                 ev,
  output logic [15:0]                             drop_count,
  output logic                                    busy
);

  // One shared phase counter; sized for the longest phase.
  localparam int MAX_AB = (FLUSH_CYCLES > SETTLE_CYCLES) ? FLUSH_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CD = (PEAK_WINDOW > DEAD_CYCLES) ? PEAK_WINDOW : DEAD_CYCLES;
  localparam int MAX_PH = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W  = $clog2(MAX_PH + 1);

  localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  // The trigger sample is the first of the window, so PEAK itself only
  // spans PEAK_WINDOW-1 cycles.
  localparam logic [CNT_W-1:0] PEAK_LAST   = CNT_W'(PEAK_WINDOW - 2);
  localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEAD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_FLUSH  = 3'd0,
    S_SETTLE = 3'd1,
    S_IDLE   = 3'd2,
    S_ARMED  = 3'd3,
    S_PEAK   = 3'd4,
    S_REPORT = 3'd5,
    S_DEAD   = 3'd6
  } state_t;

  state_t                        state;
  logic [CNT_W-1:0]              cnt;
  logic [TS_WIDTH-1:0]           ts;
  logic                          above_d;
  logic signed [SIZE_FILTER_DATA-1:0] peak;
  logic [TS_WIDTH-1:0]           ts_lat;
  logic                          pileup;
  logic                          valid;

  logic above;
  logic crossing;
  logic drop_window;

  assign above       = (filter_data > threshold);
  assign crossing    = above & ~above_d;
  assign drop_window = (state == S_REPORT) || (state == S_DEAD);

  assign ev.ev_valid     = valid;
  assign ev.ev_amplitude = peak;
  assign ev.ev_timestamp = ts_lat;
  assign ev.ev_pileup    = pileup;

  // Timestamp and crossing history run through restart untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts      <= '0;
      above_d <= 1'b0;
    end else begin
      ts      <= ts + 1'b1;
      above_d <= above;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_FLUSH;
      cnt          <= '0;
      filter_rst_n <= 1'b0;
      valid        <= 1'b0;
      peak         <= '0;
      ts_lat       <= '0;
      pileup       <= 1'b0;
      drop_count   <= '0;
      busy         <= 1'b0;
    end else if (restart) begin
      // Restart beats a same-cycle handshake: the event is dropped unsent.
      state        <= S_FLUSH;
      cnt          <= '0;
      filter_rst_n <= 1'b0;
      valid        <= 1'b0;
      peak         <= '0;
      drop_count   <= '0;
      busy         <= 1'b0;
    end else begin
      if (drop_window && crossing && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end

      case (state)
        S_FLUSH: begin
          if (cnt == FLUSH_LAST) begin
            cnt          <= '0;
            filter_rst_n <= 1'b1;
            state        <= S_SETTLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= enable ? S_ARMED : S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_IDLE: begin
          // Never arm onto a pulse that is already in progress.
          if (enable && !above) begin
            state <= S_ARMED;
          end
        end

        S_ARMED: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (above) begin
            ts_lat <= ts;
            peak   <= filter_data;
            pileup <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_PEAK;
          end
        end

        S_PEAK: begin
          if (!enable) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            if (filter_data > peak) begin
              peak <= filter_data;
            end
            if (crossing) begin
              pileup <= 1'b1;
            end
            if (cnt == PEAK_LAST) begin
              cnt   <= '0;
              valid <= 1'b1;
              state <= S_REPORT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_REPORT: begin
          // Data stays frozen until the consumer takes it.
          if (ev.ev_ready) begin
            valid <= 1'b0;
            cnt   <= '0;
            if (enable) begin
              state <= S_DEAD;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end

        S_DEAD: begin
          if (!enable) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (cnt == DEAD_LAST) begin
            // Hold here past the minimum until the input drops below level.
            if (!above) begin
              busy  <= 1'b0;
              state <= S_ARMED;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= S_FLUSH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trap_filter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_filter_sequencer
// Purpose  : Self-checking bench for trap_filter_sequencer: random pulse
//            train against an event-level reference, a table of pulse
//            shapes, and directed start-up / hold / restart / wrap sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_filter_sequencer;
  localparam int W      = 16;
  localparam int TSW    = 10;
  localparam int FLUSH  = 4;
  localparam int SETTLE = 64;
  localparam int PW     = 16;
  localparam int DEAD   = 32;
  localparam int NR     = 3000;
  localparam int RTHR   = 100;

  logic clk = 1'b0;
  logic reset, enable, restart;
  logic signed [W-1:0] threshold, filter_data;
  logic filter_rst_n, busy;
  logic [15:0] drop_count;

  trap_filter_sequencer_if #(.DATA_W(W), .TS_W(TSW)) ev ();

  trap_filter_sequencer #(
    .SIZE_FILTER_DATA(W), .TS_WIDTH(TSW), .FLUSH_CYCLES(FLUSH),
    .SETTLE_CYCLES(SETTLE), .PEAK_WINDOW(PW), .DEAD_CYCLES(DEAD)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart),
    .threshold(threshold), .filter_data(filter_data),
    .filter_rst_n(filter_rst_n), .ev(ev), .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int checks = 0;
  int failures = 0;
  int exp_drop = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int tsm(input int t);
    return t & ((1 << TSW) - 1);
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset(input bit check_vals);
    reset = 1'b0; enable = 1'b1; restart = 1'b0; ev.ev_ready = 1'b0;
    threshold = W'(RTHR); filter_data = '0;
    repeat (3) step();
    if (check_vals) begin
      chk("rst_frst", filter_rst_n, 0);
      chk("rst_valid", ev.ev_valid, 0);
      chk("rst_amp", ev.ev_amplitude, 0);
      chk("rst_ts", ev.ev_timestamp, 0);
      chk("rst_pile", ev.ev_pileup, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_busy", busy, 0);
    end
    reset = 1'b1;
  endtask

  task automatic wait_valid(input int max, output int vcyc);
    vcyc = -1;
    for (int i = 0; i < max; i++) begin
      if (ev.ev_valid) begin
        vcyc = cyc;
        break;
      end
      step();
    end
    if (vcyc < 0) chk("valid_timeout", 0, 1);
  endtask

  task automatic accept();
    ev.ev_ready = 1'b1; step(); ev.ev_ready = 1'b0;
  endtask

  // ---------------- random-run reference (event level) ----------------
  int rx[NR];
  bit rrdy[NR];
  bit e_valid[NR], e_busy[NR], e_pile[NR], drop_at[NR];
  int e_amp[NR], e_ts[NR], e_drop[NR];

  function automatic bit ab(input int k);
    return (k >= 0) && (k < NR) && (rx[k] > RTHR);
  endfunction

  function automatic bit xing(input int k);
    return ab(k) && !ab(k - 1);
  endfunction

  task automatic build_model();
    int c, t, a, k, amp, cnt;
    bit pile;
    for (int j = 0; j < NR; j++) begin
      e_valid[j] = 0; e_busy[j] = 0; e_pile[j] = 0; drop_at[j] = 0;
      e_amp[j] = 0; e_ts[j] = 0;
    end
    c = FLUSH + SETTLE;
    while (c < NR) begin
      t = c;
      while (t < NR && !ab(t)) t++;
      if (t + PW >= NR) break;
      amp = rx[t]; pile = 0;
      for (int j = t + 1; j < t + PW; j++) begin
        if (rx[j] > amp) amp = rx[j];
        if (xing(j)) pile = 1;
      end
      a = t + PW;
      while (a < NR && !rrdy[a]) a++;
      k = a + DEAD;
      while (k < NR && ab(k)) k++;
      for (int j = t + 1; j <= k && j < NR; j++) e_busy[j] = 1;
      for (int j = t + PW; j <= a && j < NR; j++) begin
        e_valid[j] = 1; e_amp[j] = amp; e_ts[j] = tsm(t); e_pile[j] = pile;
      end
      for (int j = t + PW; j <= k && j < NR; j++) if (xing(j)) drop_at[j] = 1;
      c = k + 1;
    end
    cnt = 0;
    for (int j = 0; j < NR; j++) begin
      e_drop[j] = cnt;
      cnt += int'(drop_at[j]);
    end
  endtask

  // ---------------- pulse-shape table ----------------
  typedef struct {
    int thr; int base; int s[PW]; int post; int amp; bit pile; int dinc;
  } vec_t;
  vec_t vt[8];

  task automatic set_vec(input int i, input int thr, input int base, input int post,
                         input int amp, input bit pile, input int dinc);
    vt[i].thr = thr; vt[i].base = base; vt[i].post = post;
    vt[i].amp = amp; vt[i].pile = pile; vt[i].dinc = dinc;
    for (int j = 0; j < PW; j++) vt[i].s[j] = base;
  endtask

  task automatic run_vec(input int i);
    int t;
    threshold = W'(vt[i].thr); filter_data = W'(vt[i].base);
    repeat (40) step();
    t = cyc;
    for (int j = 0; j < PW; j++) begin
      filter_data = W'(vt[i].s[j]);
      if (j == PW - 1) chk("vec_valid_early", ev.ev_valid, 0);
      step();
    end
    filter_data = W'(vt[i].post);
    chk("vec_valid", ev.ev_valid, 1);
    chk("vec_amp", ev.ev_amplitude, vt[i].amp);
    chk("vec_ts", ev.ev_timestamp, tsm(t));
    chk("vec_pile", ev.ev_pileup, vt[i].pile);
    step();
    filter_data = W'(vt[i].base);
    accept();
    chk("vec_valid_after", ev.ev_valid, 0);
    exp_drop += vt[i].dinc;
    chk("vec_drop", drop_count, exp_drop);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, v, r, a;
    bit hi;

    set_vec(0, 100, 0, 0, 300, 0, 0);
    vt[0].s[0] = 120; vt[0].s[1] = 300; vt[0].s[2] = 250; vt[0].s[3] = 90;
    set_vec(1, 100, 0, 0, 150, 1, 0);
    vt[1].s[0] = 120; vt[1].s[1] = 80; vt[1].s[2] = 150;
    set_vec(2, 100, 100, 100, 101, 0, 0);
    vt[2].s[0] = 101;
    set_vec(3, 100, 0, 500, 201, 1, 0);
    vt[3].s[0] = 150; vt[3].s[PW-1] = 201;
    set_vec(4, 100, 0, 400, 130, 0, 1);
    vt[4].s[0] = 130;
    set_vec(5, -50, -300, -300, -10, 1, 0);
    vt[5].s[0] = -49; vt[5].s[1] = -100; vt[5].s[2] = -10;
    set_vec(6, -200, -500, -500, 5, 0, 0);
    vt[6].s[0] = -150; vt[6].s[1] = 5; vt[6].s[2] = -100;
    set_vec(7, 100, 0, 0, 32767, 0, 0);
    vt[7].s[0] = 32767; vt[7].s[1] = -32768;

    // ---- random pulse train vs event-level reference ----
    hi = 0;
    for (int j = 0; j < NR; j++) begin
      if ($urandom_range(0, 9) == 0) hi = !hi;
      rx[j] = hi ? int'($urandom_range(101, 600)) : int'($urandom_range(0, 300)) - 200;
      rrdy[j] = ($urandom_range(0, 3) == 0);
    end
    build_model();
    do_reset(1'b1);
    for (int j = 0; j < NR; j++) begin
      chk("rnd_valid", ev.ev_valid, e_valid[j]);
      chk("rnd_busy", busy, e_busy[j]);
      chk("rnd_drop", drop_count, e_drop[j]);
      chk("rnd_frst", filter_rst_n, j >= FLUSH);
      if (e_valid[j]) begin
        chk("rnd_amp", ev.ev_amplitude, e_amp[j]);
        chk("rnd_ts", ev.ev_timestamp, e_ts[j]);
        chk("rnd_pile", ev.ev_pileup, e_pile[j]);
      end
      filter_data = W'(rx[j]);
      ev.ev_ready = rrdy[j];
      step();
    end

    // ---- start-up with input already above threshold ----
    do_reset(1'b0);
    filter_data = 500;
    for (int c = 0; c <= FLUSH + SETTLE + 1; c++) begin
      chk("start_frst", filter_rst_n, c >= FLUSH);
      chk("start_busy", busy, c >= FLUSH + SETTLE + 1);
      chk("start_valid", ev.ev_valid, 0);
      step();
    end
    repeat (13) step();
    chk("start_valid_early", ev.ev_valid, 0);
    step();
    chk("start_valid", ev.ev_valid, 1);
    chk("start_amp", ev.ev_amplitude, 500);
    chk("start_ts", ev.ev_timestamp, FLUSH + SETTLE);
    chk("start_pile", ev.ev_pileup, 0);
    accept();
    chk("start_valid_after", ev.ev_valid, 0);
    for (int i = 0; i < 60; i++) begin
      chk("hold_above_busy", busy, 1);
      chk("hold_above_valid", ev.ev_valid, 0);
      step();
    end
    filter_data = 0; step();
    filter_data = 500; t = cyc;
    repeat (PW) step();
    chk("rearm_valid", ev.ev_valid, 1);
    chk("rearm_ts", ev.ev_timestamp, tsm(t));
    accept();
    filter_data = 0;
    chk("start_drop", drop_count, 0);

    // ---- table of pulse shapes ----
    exp_drop = 0;
    for (int i = 0; i < 8; i++) run_vec(i);

    // ---- restart in REPORT together with ready ----
    threshold = 100; filter_data = 0;
    repeat (40) step();
    filter_data = 200; step(); filter_data = 0;
    wait_valid(PW + 4, v);
    restart = 1'b1; ev.ev_ready = 1'b1; filter_data = 500; r = cyc;
    step();
    restart = 1'b0; ev.ev_ready = 1'b0;
    chk("rs_valid", ev.ev_valid, 0);
    chk("rs_drop", drop_count, 0);
    chk("rs_busy", busy, 0);
    for (int i = 0; i < FLUSH; i++) begin
      chk("rs_frst_low", filter_rst_n, 0);
      step();
    end
    chk("rs_frst_high", filter_rst_n, 1);
    repeat (SETTLE + PW - 1) step();
    chk("rs_valid_early", ev.ev_valid, 0);
    step();
    chk("rs_valid", ev.ev_valid, 1);
    chk("rs_ts", ev.ev_timestamp, tsm(r + 1 + FLUSH + SETTLE));
    chk("rs_amp", ev.ev_amplitude, 500);
    accept();
    filter_data = 0;

    // ---- ready held low while further crossings arrive ----
    repeat (40) step();
    t = cyc; filter_data = 200; step(); filter_data = 0;
    wait_valid(PW + 4, v);
    chk("hold_latency", v, t + PW);
    for (int i = 0; i < 40; i++) begin
      chk("hold_stable", ev.ev_valid && (ev.ev_amplitude == 200) && (ev.ev_timestamp == TSW'(tsm(t))), 1);
      filter_data = ((i % 10) < 2 && i < 30) ? 16'sd250 : 16'sd0;
      step();
    end
    chk("hold_drop", drop_count, 3);
    filter_data = 0; a = cyc;
    accept();
    chk("dead_valid", ev.ev_valid, 0);
    for (int i = 0; i < DEAD; i++) begin
      chk("dead_busy", busy, 1);
      step();
    end
    chk("dead_end_busy", busy, 0);
    t = cyc;
    chk("dead_len", t, a + 1 + DEAD);
    filter_data = 200; step(); filter_data = 0;
    repeat (PW - 1) step();
    chk("dead_rearm_valid", ev.ev_valid, 1);
    chk("dead_rearm_ts", ev.ev_timestamp, tsm(t));
    accept();

    // ---- event straddling timestamp wrap ----
    repeat (40) step();
    for (int i = 0; i < 1100 && tsm(cyc) != 1015; i++) step();
    t = cyc; filter_data = 200; step(); filter_data = 0;
    wait_valid(PW + 4, v);
    chk("wrap_latency", v, t + PW);
    chk("wrap_ts", ev.ev_timestamp, 1015);
    accept();

    // ---- enable dropped inside the peak window ----
    repeat (40) step();
    filter_data = 200; step(); filter_data = 0;
    repeat (4) step();
    enable = 1'b0; step();
    chk("dis_busy", busy, 0);
    for (int i = 0; i < 30; i++) begin
      chk("dis_no_valid", ev.ev_valid, 0);
      step();
    end
    enable = 1'b1;
    repeat (3) step();
    t = cyc; filter_data = 200; step(); filter_data = 0;
    wait_valid(PW + 4, v);
    chk("dis_ts", ev.ev_timestamp, tsm(t));
    chk("dis_drop", drop_count, 3);
    accept();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
